// File: rtl/idex_stage_pkg.sv
// Shared xgriscv definitions used at the ID/EX boundary: datapath width,
// ALU control codes, operand-select codes and the pipeline register layout.
package idex_stage_pkg;

  localparam int XLEN = 32;

  // ALU control codes
  localparam logic [3:0] ALU_CTRL_ZERO = 4'b0000;
  localparam logic [3:0] ALU_CTRL_ADD  = 4'b0001;
  localparam logic [3:0] ALU_CTRL_SUB  = 4'b0010;
  localparam logic [3:0] ALU_CTRL_AND  = 4'b0011;
  localparam logic [3:0] ALU_CTRL_OR   = 4'b0100;
  localparam logic [3:0] ALU_CTRL_XOR  = 4'b0101;
  localparam logic [3:0] ALU_CTRL_SLL  = 4'b0110;
  localparam logic [3:0] ALU_CTRL_SRL  = 4'b0111;
  localparam logic [3:0] ALU_CTRL_SRA  = 4'b1000;
  localparam logic [3:0] ALU_CTRL_SLT  = 4'b1001;
  localparam logic [3:0] ALU_CTRL_SLTU = 4'b1010;

  // A-operand source select
  localparam logic [1:0] ASEL_RS1  = 2'd0;
  localparam logic [1:0] ASEL_PC   = 2'd1;
  localparam logic [1:0] ASEL_ZERO = 2'd2;

  // B-operand source select
  localparam logic BSEL_RS2 = 1'b0;
  localparam logic BSEL_IMM = 1'b1;

  // Everything held in the ID/EX pipeline register
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [XLEN-1:0] imm;
    logic [4:0]      shamt;
    logic [3:0]      aluctrl;
    logic [1:0]      asel;
    logic            bsel;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            branch;
    logic [2:0]      brtype;
  } idex_reg_t;

  // Turn a slot into a bubble: kill validity and every side effect, leave data.
  function automatic idex_reg_t make_bubble(input idex_reg_t r);
    idex_reg_t b;
    b          = r;
    b.valid    = 1'b0;
    b.regwrite = 1'b0;
    b.memread  = 1'b0;
    b.memwrite = 1'b0;
    b.branch   = 1'b0;
    b.aluctrl  = ALU_CTRL_ZERO;
    b.rd       = 5'd0;
    return b;
  endfunction

endpackage

// File: rtl/idex_stage_fwd_mux.sv
// Operand forwarding for one source register: MEM result beats WB result,
// which beats the register-file value latched at ID. x0 is never forwarded.
import idex_stage_pkg::*;

module idex_stage_fwd_mux (
  input  logic [4:0]      rs,
  input  logic [XLEN-1:0] rdata,
  input  logic            mem_regwrite,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] fwd
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_regwrite && (mem_rd != 5'd0) && (mem_rd == rs);
  assign wb_hit  = wb_regwrite  && (wb_rd  != 5'd0) && (wb_rd  == rs);

  // Priority select: youngest producer first
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    fwd = rdata;
    if (mem_hit)     fwd = mem_data;
    else if (wb_hit) fwd = wb_data;
  end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with EX-side operand selection, forwarding,
// load-use hazard detection and bubble/flush handling.
import idex_stage_pkg::*;

module idex_stage (
  input  logic            clk,
  input  logic            rstn,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic [XLEN-1:0] id_rdata1,
  input  logic [XLEN-1:0] id_rdata2,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_shamt,
  input  logic [3:0]      id_aluctrl,
  input  logic [1:0]      id_asel,
  input  logic            id_bsel,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic            id_branch,
  input  logic [2:0]      id_brtype,
  input  logic            mem_regwrite,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  input  logic            stall_in,
  output logic            load_use_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [4:0]      ex_shamt,
  output logic [3:0]      ex_aluctrl,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_branch,
  output logic [2:0]      ex_brtype
);

  idex_reg_t id_fields;
  idex_reg_t ex_q;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic rs_match;

  // Pack the ID fields; an invalid ID slot enters EX as a bubble
  always_comb begin
    id_fields          = '0;
    id_fields.valid    = id_valid;
    id_fields.pc       = id_pc;
    id_fields.rs1      = id_rs1;
    id_fields.rs2      = id_rs2;
    id_fields.rd       = id_rd;
    id_fields.rdata1   = id_rdata1;
    id_fields.rdata2   = id_rdata2;
    id_fields.imm      = id_imm;
    id_fields.shamt    = id_shamt;
    id_fields.aluctrl  = id_aluctrl;
    id_fields.asel     = id_asel;
    id_fields.bsel     = id_bsel;
    id_fields.regwrite = id_regwrite;
    id_fields.memread  = id_memread;
    id_fields.memwrite = id_memwrite;
    id_fields.branch   = id_branch;
    id_fields.brtype   = id_brtype;
    if (!id_valid) id_fields = make_bubble(id_fields);
  end

  // Load-use hazard: the load in EX produces a register ID wants to read.
  // The stall never lasts more than a cycle because the slot it creates is a bubble.
  assign rs_match = (id_uses_rs1 && (id_rs1 == ex_q.rd)) ||
                    (id_uses_rs2 && (id_rs2 == ex_q.rd));
  assign load_use_stall = !flush && ex_q.valid && ex_q.memread &&
                          (ex_q.rd != 5'd0) && id_valid && rs_match;

  // Pipeline register update: flush > stall_in > load-use bubble > capture
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: this is a flop register, not a memory array, so it is reset in full; sequential state uses non-blocking assignments only.
    if (!rstn)               ex_q <= '0;
    else if (flush)          ex_q <= make_bubble(ex_q);
    else if (stall_in)       ex_q <= ex_q;
    else if (load_use_stall) ex_q <= make_bubble(ex_q);
    else                     ex_q <= id_fields;
  end

  idex_stage_fwd_mux u_fwd_rs1 (
    .rs           (ex_q.rs1),
    .rdata        (ex_q.rdata1),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .fwd          (fwd_rs1)
  );

  idex_stage_fwd_mux u_fwd_rs2 (
    .rs           (ex_q.rs2),
    .rdata        (ex_q.rdata2),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .fwd          (fwd_rs2)
  );

  // ALU operand selection; asel = 3 falls through to zero like ASEL_ZERO
  always_comb begin
    ex_a = '0;
    case (ex_q.asel)
      ASEL_RS1: ex_a = fwd_rs1;
      ASEL_PC:  ex_a = ex_q.pc;
      default:  ex_a = '0;
    endcase
    ex_b     = (ex_q.bsel == BSEL_IMM) ? ex_q.imm   : fwd_rs2;
    ex_shamt = (ex_q.bsel == BSEL_IMM) ? ex_q.shamt : fwd_rs2[4:0];
  end

  assign ex_store_data = fwd_rs2;
  assign ex_valid      = ex_q.valid;
  assign ex_aluctrl    = ex_q.aluctrl;
  assign ex_pc         = ex_q.pc;
  assign ex_imm        = ex_q.imm;
  assign ex_rd         = ex_q.rd;
  assign ex_regwrite   = ex_q.regwrite;
  assign ex_memread    = ex_q.memread;
  assign ex_memwrite   = ex_q.memwrite;
  assign ex_branch     = ex_q.branch;
  assign ex_brtype     = ex_q.brtype;

endmodule

// File: tb/tb_idex_stage.sv
// Directed bench for idex_stage: capture, forwarding priority, load-use
// bubble, LUI/AUIPC operand select, shift amount, flush/stall and reset.
`timescale 1ns/1ps
import idex_stage_pkg::*;

module tb_idex_stage;

  logic            clk = 1'b0;
  logic            rstn;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic            id_uses_rs1, id_uses_rs2;
  logic [XLEN-1:0] id_rdata1, id_rdata2, id_imm;
  logic [4:0]      id_shamt;
  logic [3:0]      id_aluctrl;
  logic [1:0]      id_asel;
  logic            id_bsel;
  logic            id_regwrite, id_memread, id_memwrite, id_branch;
  logic [2:0]      id_brtype;
  logic            mem_regwrite;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            wb_regwrite;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            flush, stall_in;
  logic            load_use_stall, ex_valid;
  logic [XLEN-1:0] ex_a, ex_b, ex_store_data, ex_pc, ex_imm;
  logic [4:0]      ex_shamt, ex_rd;
  logic [3:0]      ex_aluctrl;
  logic            ex_regwrite, ex_memread, ex_memwrite, ex_branch;
  logic [2:0]      ex_brtype;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  idex_stage dut (
    .clk(clk), .rstn(rstn),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_aluctrl(id_aluctrl),
    .id_asel(id_asel), .id_bsel(id_bsel),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_branch(id_branch), .id_brtype(id_brtype),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .stall_in(stall_in),
    .load_use_stall(load_use_stall), .ex_valid(ex_valid),
    .ex_a(ex_a), .ex_b(ex_b), .ex_shamt(ex_shamt), .ex_aluctrl(ex_aluctrl),
    .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_branch(ex_branch), .ex_brtype(ex_brtype)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_clear();
    id_valid = 0; id_pc = '0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; id_rdata1 = '0; id_rdata2 = '0;
    id_imm = '0; id_shamt = 0; id_aluctrl = ALU_CTRL_ZERO; id_asel = ASEL_RS1;
    id_bsel = BSEL_RS2; id_regwrite = 0; id_memread = 0; id_memwrite = 0;
    id_branch = 0; id_brtype = 0;
  endtask

  task automatic fwd_clear();
    mem_regwrite = 0; mem_rd = 0; mem_data = '0;
    wb_regwrite = 0; wb_rd = 0; wb_data = '0;
  endtask

  // LW x4, 0(x1)
  task automatic id_lw_x4();
    id_clear();
    id_valid = 1; id_rs1 = 5'd1; id_uses_rs1 = 1; id_rd = 5'd4;
    id_rdata1 = 32'h100; id_bsel = BSEL_IMM; id_aluctrl = ALU_CTRL_ADD;
    id_regwrite = 1; id_memread = 1;
  endtask

  // ADD x6, x4, x2
  task automatic id_add_dep();
    id_clear();
    id_valid = 1; id_rs1 = 5'd4; id_rs2 = 5'd2; id_uses_rs1 = 1; id_uses_rs2 = 1;
    id_rd = 5'd6; id_rdata1 = 32'hAA; id_rdata2 = 32'hBB;
    id_aluctrl = ALU_CTRL_ADD; id_regwrite = 1;
  endtask

  initial begin
    rstn = 0; flush = 0; stall_in = 0;
    id_clear();
    fwd_clear();

    // Reset state
    #3;
    check("rst_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_a", ex_a, 32'd0);
    check("rst_b", ex_b, 32'd0);
    check("rst_aluctrl", {28'd0, ex_aluctrl}, {28'd0, ALU_CTRL_ZERO});
    check("rst_lus", {31'd0, load_use_stall}, 32'd0);
    #9 rstn = 1;

    // ADDI x5, x1, 7 with rdata1 = 10
    id_valid = 1; id_rs1 = 5'd1; id_uses_rs1 = 1; id_rd = 5'd5;
    id_rdata1 = 32'd10; id_imm = 32'd7; id_bsel = BSEL_IMM;
    id_aluctrl = ALU_CTRL_ADD; id_regwrite = 1;
    step();
    check("addi_a", ex_a, 32'd10);
    check("addi_b", ex_b, 32'd7);
    check("addi_aluctrl", {28'd0, ex_aluctrl}, {28'd0, ALU_CTRL_ADD});
    check("addi_valid", {31'd0, ex_valid}, 32'd1);
    check("addi_rd", {27'd0, ex_rd}, 32'd5);
    check("addi_regwrite", {31'd0, ex_regwrite}, 32'd1);

    // ADD x7, x3, x2 -> forwarding on rs1 = 3
    id_clear();
    id_valid = 1; id_rs1 = 5'd3; id_rs2 = 5'd2; id_uses_rs1 = 1; id_uses_rs2 = 1;
    id_rd = 5'd7; id_rdata1 = 32'h99; id_rdata2 = 32'h5;
    id_aluctrl = ALU_CTRL_ADD; id_regwrite = 1;
    step();
    mem_regwrite = 1; mem_rd = 5'd3; mem_data = 32'h11;
    wb_regwrite = 1; wb_rd = 5'd3; wb_data = 32'h22;
    #1 check("fwd_mem_prio", ex_a, 32'h11);
    check("fwd_rs2_none", ex_b, 32'h5);
    mem_regwrite = 0;
    #1 check("fwd_wb", ex_a, 32'h22);
    mem_regwrite = 1; mem_rd = 5'd0; wb_rd = 5'd0;
    #1 check("fwd_x0_none", ex_a, 32'h99);
    wb_rd = 5'd2; wb_data = 32'h33;
    #1 check("fwd_wb_rs2_b", ex_b, 32'h33);
    check("fwd_wb_store", ex_store_data, 32'h33);
    fwd_clear();

    // Load-use: EX = LW x4, ID = ADD x6, x4, x2
    id_lw_x4();
    #1 check("lus_not_yet", {31'd0, load_use_stall}, 32'd0);
    step();
    id_add_dep();
    #1 check("lus_assert", {31'd0, load_use_stall}, 32'd1);
    step();
    check("lus_bubble_valid", {31'd0, ex_valid}, 32'd0);
    check("lus_bubble_flags", {28'd0, ex_regwrite, ex_memread, ex_memwrite, ex_branch}, 32'd0);
    check("lus_bubble_rd", {27'd0, ex_rd}, 32'd0);
    check("lus_bubble_aluctrl", {28'd0, ex_aluctrl}, {28'd0, ALU_CTRL_ZERO});
    check("lus_one_cycle", {31'd0, load_use_stall}, 32'd0);
    step();
    check("lus_add_valid", {31'd0, ex_valid}, 32'd1);
    check("lus_add_rd", {27'd0, ex_rd}, 32'd6);
    check("lus_add_a", ex_a, 32'hAA);

    // LUI x8, 0x12345
    id_clear();
    id_valid = 1; id_pc = 32'h80; id_rd = 5'd8; id_rdata1 = 32'h77;
    id_imm = 32'h12345000; id_asel = ASEL_ZERO; id_bsel = BSEL_IMM;
    id_aluctrl = ALU_CTRL_ADD; id_regwrite = 1;
    step();
    check("lui_a", ex_a, 32'd0);
    check("lui_b", ex_b, 32'h12345000);
    // AUIPC x8, 0x12345
    id_asel = ASEL_PC;
    step();
    check("auipc_a", ex_a, 32'h80);
    check("auipc_b", ex_b, 32'h12345000);
    check("auipc_pc", ex_pc, 32'h80);
    // asel = 3 behaves as zero
    id_asel = 2'd3;
    step();
    check("asel3_a", ex_a, 32'd0);

    // SLLI: shamt comes from the instruction field
    id_clear();
    id_valid = 1; id_rs1 = 5'd1; id_uses_rs1 = 1; id_rd = 5'd9;
    id_shamt = 5'd17; id_bsel = BSEL_IMM; id_aluctrl = ALU_CTRL_SLL; id_regwrite = 1;
    step();
    check("slli_shamt", {27'd0, ex_shamt}, 32'd17);

    // SLL x9, x1, x10 with forwarded rs2 = 0x25
    id_clear();
    id_valid = 1; id_rs1 = 5'd1; id_rs2 = 5'd10; id_uses_rs1 = 1; id_uses_rs2 = 1;
    id_rd = 5'd9; id_rdata2 = 32'h3; id_shamt = 5'd17; id_bsel = BSEL_RS2;
    id_aluctrl = ALU_CTRL_SLL; id_regwrite = 1;
    step();
    mem_regwrite = 1; mem_rd = 5'd10; mem_data = 32'h25;
    #1 check("sll_shamt_fwd", {27'd0, ex_shamt}, 32'd5);
    check("sll_b_fwd", ex_b, 32'h25);
    fwd_clear();

    // stall_in alone for 3 cycles: SLL stays in EX
    stall_in = 1;
    id_clear();
    id_valid = 1; id_rd = 5'd12; id_aluctrl = ALU_CTRL_ADD; id_regwrite = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_rd", {27'd0, ex_rd}, 32'd9);
      check("stall_aluctrl", {28'd0, ex_aluctrl}, {28'd0, ALU_CTRL_SLL});
      check("stall_valid", {31'd0, ex_valid}, 32'd1);
      check("stall_b", ex_b, 32'h3);
    end
    // flush together with stall_in: bubble
    flush = 1;
    step();
    check("flush_stall_valid", {31'd0, ex_valid}, 32'd0);
    check("flush_stall_rd", {27'd0, ex_rd}, 32'd0);
    check("flush_stall_regwrite", {31'd0, ex_regwrite}, 32'd0);
    flush = 0; stall_in = 0;

    // flush masks load_use_stall
    id_lw_x4();
    step();
    id_add_dep();
    #1 check("lus_pre_flush", {31'd0, load_use_stall}, 32'd1);
    flush = 1;
    #1 check("lus_flush_mask", {31'd0, load_use_stall}, 32'd0);
    step();
    check("flush_valid", {31'd0, ex_valid}, 32'd0);
    flush = 0;

    // Reset asserted mid-stall, between edges
    id_lw_x4();
    step();
    id_add_dep();
    #1 check("lus_pre_reset", {31'd0, load_use_stall}, 32'd1);
    #1 rstn = 0;
    #1;
    check("reset_valid", {31'd0, ex_valid}, 32'd0);
    check("reset_lus", {31'd0, load_use_stall}, 32'd0);
    check("reset_a", ex_a, 32'd0);
    check("reset_b", ex_b, 32'd0);
    check("reset_rd", {27'd0, ex_rd}, 32'd0);
    check("reset_memread", {31'd0, ex_memread}, 32'd0);
    check("reset_aluctrl", {28'd0, ex_aluctrl}, {28'd0, ALU_CTRL_ZERO});
    rstn = 1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
